// File: rtl/fwd_hazard_tracker.sv
// EX-stage forwarding select and load-use stall generator with its own in-flight destination pipeline.
// Optional FWD_HAZARD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          load_use_stall
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]                   stall_count,
    output logic [15:0]                   fwd_count
`endif
);

    // Entry 0 is ID/EX; entry k holds the instruction k registers past EX.
    logic                  vld_p [0:FWD_DEPTH];
    logic                  rw_p  [0:FWD_DEPTH];
    logic [REG_ADDR_W-1:0] rd_p  [0:FWD_DEPTH];
    logic                  mr_p0;
    logic [REG_ADDR_W-1:0] exSrc_p0 [NUM_SRC];
    logic [NUM_SRC-1:0]    exUsed_p0;
    logic                  srcHit;

    always_comb begin
        srcHit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == rd_p[0]))
                srcHit = 1'b1;
        end
        load_use_stall = id_valid && vld_p[0] && rw_p[0] && mr_p0 &&
                         (rd_p[0] != '0) && srcHit && !flush;
    end

    // Scan far-to-near so the nearest matching stage overwrites farther ones.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (exUsed_p0[i] && (exSrc_p0[i] != '0) && vld_p[k] && rw_p[k] &&
                    (rd_p[k] == exSrc_p0[i]))
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                vld_p[k] <= 1'b0;
                rw_p[k]  <= 1'b0;
                rd_p[k]  <= '0;
            end
            mr_p0 <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++)
                exSrc_p0[i] <= '0;
            exUsed_p0 <= '0;
        end else if (!hold) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                vld_p[k] <= vld_p[k-1];
                rw_p[k]  <= rw_p[k-1];
                rd_p[k]  <= rd_p[k-1];
            end
            if (flush || load_use_stall) begin
                vld_p[0]  <= 1'b0;
                rw_p[0]   <= 1'b0;
                rd_p[0]   <= '0;
                mr_p0     <= 1'b0;
                exUsed_p0 <= '0;
            end else begin
                vld_p[0]  <= id_valid;
                rw_p[0]   <= id_regwrite;
                rd_p[0]   <= id_rd;
                mr_p0     <= id_memread;
                // An empty ID slot never reads, so it can never request a forward.
                exUsed_p0 <= id_valid ? id_src_used : '0;
                for (int i = 0; i < NUM_SRC; i++)
                    exSrc_p0[i] <= id_src[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    function automatic logic [15:0] satInc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else if (!hold) begin
            if (load_use_stall)
                stall_count <= satInc(stall_count);
            if (|fwd_sel)
                fwd_count <= satInc(fwd_count);
        end
    end
`endif

endmodule
